// File: rtl/button_conditioner.sv
// button_conditioner: per-button 2-flop sync, debounce, press/release pulses and auto-repeat
// for the five raw push-buttons, bit order {C,L,U,R,D}.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bC,
  input  logic       bL,
  input  logic       bU,
  input  logic       bR,
  input  logic       bD,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press,
  output logic [4:0] btn_release,
  output logic       btn_any
);
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [4:0]    raw;
  logic [4:0]    s1_q, s1_d, s2_q, s2_d, db_q, db_d;
  logic [4:0]    press_q, press_d, rel_q, rel_d;
  logic          any_q, any_d;
  logic [4:0]    rise, fire;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];
  logic [RW-1:0] rcnt_q [5];
  logic [RW-1:0] rcnt_d [5];
  state_t        st_q [5];
  state_t        st_d [5];

  assign raw = {bC, bL, bU, bR, bD};

  always_comb begin
    s1_d    = raw;
    s2_d    = s1_q;
    db_d    = db_q;
    rise    = '0;
    fire    = '0;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i]   = (s2_q[i] == db_q[i] || cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt_q[i] + 1'b1;
      db_d[i]    = (s2_q[i] != db_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? s2_q[i] : db_q[i];
      rise[i]    = db_d[i] & ~db_q[i];
      fire[i]    = (st_q[i] == DELAY && rcnt_q[i] == RW'(REPEAT_DELAY)) ||
                   (st_q[i] == REPEAT && rcnt_q[i] == RW'(REPEAT_PERIOD));
      // A release on this edge wins over any repeat pulse that was due.
      st_d[i]    = (REPEAT_EN == 0 || !db_d[i]) ? IDLE :
                   rise[i] ? DELAY :
                   (st_q[i] == DELAY && fire[i]) ? REPEAT : st_q[i];
      rcnt_d[i]  = (st_d[i] == IDLE) ? '0 : (rise[i] || fire[i]) ? RW'(1) : rcnt_q[i] + 1'b1;
      press_d[i] = rise[i] | (db_d[i] & fire[i]);
      rel_d[i]   = db_q[i] & ~db_d[i];
    end
    any_d = |db_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      db_q    <= '0;
      press_q <= '0;
      rel_q   <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i]  <= '0;
        rcnt_q[i] <= '0;
        st_q[i]   <= IDLE;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      db_q    <= db_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      any_q   <= any_d;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i]  <= cnt_d[i];
        rcnt_q[i] <= rcnt_d[i];
        st_q[i]   <= st_d[i];
      end
    end
  end

  assign btn_level   = db_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;
  assign btn_any     = any_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed timing scenarios plus randomized button traffic, compared
// against an abstract model (history-window debounce, hold-age repeat schedule).
module tb_button_conditioner;
  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bC = 1'b0, bL = 1'b0, bU = 1'b0, bR = 1'b0, bD = 1'b0;
  logic [4:0] lv1, pr1, rl1, lv2, pr2, rl2;
  logic any1, any2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(DC), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_rep (
    .clk(clk), .rst_n(rst_n), .bC(bC), .bL(bL), .bU(bU), .bR(bR), .bD(bD),
    .btn_level(lv1), .btn_press(pr1), .btn_release(rl1), .btn_any(any1));

  button_conditioner #(.DEBOUNCE_CYCLES(DC), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_norep (
    .clk(clk), .rst_n(rst_n), .bC(bC), .bL(bL), .bU(bU), .bR(bR), .bD(bD),
    .btn_level(lv2), .btn_press(pr2), .btn_release(rl2), .btn_any(any2));

  // Reference model: a button's level flips once the last DC synchronised samples all disagree
  // with it; repeat pulses fall at hold ages RD, RD+RP, RD+2RP, ...
  logic [4:0] m_s1, m_s2, m_db, m_p1, m_p0, m_rel, ndbv;
  logic m_any;
  logic [DC-1:0] mh [5];
  int m_age [5];
  logic [DC-1:0] nh;
  logic ndb, mrise;
  int age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_db <= '0; m_p1 <= '0; m_p0 <= '0; m_rel <= '0; m_any <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        mh[i] <= '0;
        m_age[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        nh = {mh[i][DC-2:0], m_s2[i]};
        ndb = (nh == {DC{~m_db[i]}}) ? ~m_db[i] : m_db[i];
        mrise = ndb & ~m_db[i];
        age = mrise ? 0 : (ndb ? m_age[i] + 1 : 0);
        ndbv[i] = ndb;
        mh[i] <= nh;
        m_db[i] <= ndb;
        m_age[i] <= age;
        m_p0[i] <= mrise;
        m_p1[i] <= mrise | (ndb && age >= RD && (age - RD) % RP == 0);
        m_rel[i] <= m_db[i] & ~ndb;
      end
      m_s1 <= {bC, bL, bU, bR, bD};
      m_s2 <= m_s1;
      m_any <= |ndbv;
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({lv1, pr1, rl1, any1} !== {m_db, m_p1, m_rel, m_any}) begin
      errors++;
      $display("FAIL sb_repeat t=%0t got lv=%b pr=%b rl=%b any=%b exp lv=%b pr=%b rl=%b any=%b",
               $time, lv1, pr1, rl1, any1, m_db, m_p1, m_rel, m_any);
    end
    checks++;
    if ({lv2, pr2, rl2, any2} !== {m_db, m_p0, m_rel, m_any}) begin
      errors++;
      $display("FAIL sb_norepeat t=%0t got lv=%b pr=%b rl=%b any=%b exp lv=%b pr=%b rl=%b any=%b",
               $time, lv2, pr2, rl2, any2, m_db, m_p0, m_rel, m_any);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    {bC, bL, bU, bR, bD} = 5'b11111;
    idle(3);
    checks++;
    if ({lv1, pr1, rl1, any1, lv2, pr2, rl2, any2} !== '0) begin
      errors++;
      $display("FAIL reset_state got %b exp 0", {lv1, pr1, rl1, any1, lv2, pr2, rl2, any2});
    end
    {bC, bL, bU, bR, bD} = 5'b00000;
    idle(2);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(4);
  endtask

  task automatic test_hold_d();
    bD = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      checks++;
      if (pr1[0] !== (k == 6 || k == 26 || k == 34 || k == 42)) begin
        errors++; $display("FAIL hold_press edge=%0d got %b", k, pr1[0]);
      end
      checks++;
      if (rl1[0] !== (k == 46)) begin
        errors++; $display("FAIL hold_release edge=%0d got %b", k, rl1[0]);
      end
      checks++;
      if (lv1[0] !== (k >= 6 && k < 46)) begin
        errors++; $display("FAIL hold_level edge=%0d got %b", k, lv1[0]);
      end
      if (k == 40) bD = 1'b0;
    end
    idle(4);
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 30; k++) begin
      bU = (k < 3) || (k >= 10 && k < 13);
      step();
      checks++;
      if ({lv1, pr1, rl1, any1} !== '0) begin
        errors++; $display("FAIL glitch edge=%0d got %b exp 0", k + 1, {lv1, pr1, rl1, any1});
      end
    end
  endtask

  task automatic test_chatter();
    int n = 0;
    int at = -1;
    for (int k = 0; k < 40; k++) begin
      bU = (k < 20) ? ((k / 2) % 2 == 0) : 1'b1;
      step();
      if (pr1[2]) begin
        n++;
        at = k + 1;
      end
    end
    checks++;
    if (n != 1 || at != 26) begin
      errors++; $display("FAIL chatter got count=%0d edge=%0d exp count=1 edge=26", n, at);
    end
    bU = 1'b0;
    idle(12);
  endtask

  task automatic test_simultaneous();
    bL = 1'b1;
    bR = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      checks++;
      if ({pr1[3], pr1[1]} !== {2{k == 6}}) begin
        errors++; $display("FAIL simul_press edge=%0d got %b", k, {pr1[3], pr1[1]});
      end
      checks++;
      if (any1 !== (k >= 6 && k < 16)) begin
        errors++; $display("FAIL simul_any edge=%0d got %b", k, any1);
      end
      checks++;
      if ({rl1[3], rl1[1]} !== {2{k == 16}}) begin
        errors++; $display("FAIL simul_release edge=%0d got %b", k, {rl1[3], rl1[1]});
      end
      if (k == 10) begin
        bL = 1'b0;
        bR = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    bC = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      checks++;
      if (pr1[4] !== (k == 6 || k == 26) || rl1[4] !== 1'b0) begin
        errors++; $display("FAIL rstmid_pulse edge=%0d got press=%b release=%b", k, pr1[4], rl1[4]);
      end
      checks++;
      if (lv1[4] !== ((k >= 6 && k < 15) || k >= 26)) begin
        errors++; $display("FAIL rstmid_level edge=%0d got %b", k, lv1[4]);
      end
      if (k == 14) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({lv1, pr1, rl1, any1, lv2, pr2, rl2, any2} !== '0) begin
          errors++; $display("FAIL rstmid_async got %b exp 0", {lv1, pr1, rl1, any1, lv2, pr2, rl2, any2});
        end
      end
      if (k == 20) #2 rst_n = 1'b1;
    end
    bC = 1'b0;
    idle(12);
  endtask

  task automatic test_no_repeat();
    int np2 = 0, nr2 = 0, np1 = 0;
    bD = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      step();
      np2 += int'(pr2[0]);
      nr2 += int'(rl2[0]);
      np1 += int'(pr1[0]);
      if (k == 100) bD = 1'b0;
    end
    checks++;
    if (np2 != 1 || nr2 != 1) begin
      errors++; $display("FAIL norepeat got press=%0d release=%0d exp 1 1", np2, nr2);
    end
    checks++;
    if (np1 != 11) begin
      errors++; $display("FAIL repeat_count got %0d exp 11", np1);
    end
  endtask

  task automatic test_random();
    int hold [5];
    int seen = 0, want = 0;
    logic [4:0] b;
    for (int i = 0; i < 5; i++) hold[i] = 0;
    b = '0;
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < 5; i++) begin
        if (hold[i] == 0) begin
          b[i] = ~b[i];
          hold[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 70) : $urandom_range(1, 8);
        end else hold[i]--;
      end
      {bC, bL, bU, bR, bD} = b;
      if (k == 2000) #2 rst_n = 1'b0;
      if (k == 2003) #2 rst_n = 1'b1;
      step();
      seen += $countones(pr1);
      want += $countones(m_p1);
    end
    checks++;
    if (seen != want) begin
      errors++; $display("FAIL random_press_total got %0d exp %0d", seen, want);
    end
    {bC, bL, bU, bR, bD} = '0;
    idle(12);
  endtask

  initial begin
    test_reset();
    test_hold_d();
    test_glitch();
    test_chatter();
    test_simultaneous();
    test_reset_mid();
    test_no_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
